// File: rtl/clk_div_prog.sv
// Programmable integer clock divider with glitch-free divisor updates at period boundaries.
// Optional macro CLK_DIV_ODD_DUTY50_EN adds a falling-edge stage for 50% duty on odd divisors.
module clk_div_prog #(
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned DIV_DEFAULT = 4
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
    input  logic [CNT_W-1:0] div_val,
    input  logic             div_wr,
    output logic             clk_out,
    output logic             clk_en_pulse,
    output logic [CNT_W-1:0] div_active,
    output logic             div_pend,
    output logic             div_err
);

    localparam logic [CNT_W-1:0] DivRst = CNT_W'(DIV_DEFAULT);
    localparam logic [CNT_W-1:0] DivMin = CNT_W'(2);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] pval_q, pval_d;
    logic             pend_q, pend_d;
    logic             err_q, err_d;
    logic             clk_q, clk_d;
    logic             wrap, apply, wr_ok;

    always_comb begin
        wrap   = en && (cnt_q == div_q - CNT_W'(1));
        // Stopping the divider is also a safe point to swap the divisor.
        apply  = pend_q && (wrap || !en);
        wr_ok  = div_wr && (div_val >= DivMin);

        div_d  = apply ? pval_q : div_q;
        cnt_d  = (!en || wrap) ? '0 : cnt_q + CNT_W'(1);

        pend_d = pend_q;
        pval_d = pval_q;
        if (apply) begin
            pend_d = 1'b0;
        end
        // A write in the wrap cycle waits for the following boundary.
        if (wr_ok) begin
            pend_d = 1'b1;
            pval_d = div_val;
        end

        err_d  = div_wr && !(div_val >= DivMin);
        clk_d  = en && (cnt_d >= (div_d >> 1));
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            cnt_q  <= '0;
            div_q  <= DivRst;
            pval_q <= '0;
            pend_q <= 1'b0;
            err_q  <= 1'b0;
            clk_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            div_q  <= div_d;
            pval_q <= pval_d;
            pend_q <= pend_d;
            err_q  <= err_d;
            clk_q  <= clk_d;
        end
    end

`ifdef CLK_DIV_ODD_DUTY50_EN
    logic clk_n_q;

    // Half-cycle delayed copy trims the extra high half-period of odd divisors.
    always_ff @(negedge clk_in) begin
        if (rst) begin
            clk_n_q <= 1'b0;
        end else begin
            clk_n_q <= clk_q;
        end
    end

    assign clk_out = div_q[0] ? (clk_q & clk_n_q) : clk_q;
`else
    assign clk_out = clk_q;
`endif

    assign clk_en_pulse = wrap;
    assign div_active   = div_q;
    assign div_pend     = pend_q;
    assign div_err      = err_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Self-checking bench for clk_div_prog: directed scenarios plus randomized traffic
// checked every cycle against a period-position reference model.
module tb_clk_div_prog;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       div_wr = 1'b0;
    logic [7:0] div_val = '0;
    logic       clk_out, clk_en_pulse, div_pend, div_err;
    logic [7:0] div_active;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: position within the current period, period length, pending request.
    int m_pos, m_n, m_pend, m_pval, m_err;
    logic last_clk, last_pulse;

    clk_div_prog #(.CNT_W(8), .DIV_DEFAULT(4)) dut (
        .clk_in      (clk),
        .rst         (rst),
        .en          (en),
        .div_val     (div_val),
        .div_wr      (div_wr),
        .clk_out     (clk_out),
        .clk_en_pulse(clk_en_pulse),
        .div_active  (div_active),
        .div_pend    (div_pend),
        .div_err     (div_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int exp_clk();
`ifdef CLK_DIV_ODD_DUTY50_EN
        if (m_n % 2 == 1) return (m_pos > m_n / 2) ? 1 : 0;
`endif
        return (m_pos >= m_n / 2) ? 1 : 0;
    endfunction

    task automatic model_reset();
        m_pos = 0; m_n = 4; m_pend = 0; m_pval = 0; m_err = 0;
    endtask

    // One clock cycle: drive inputs, compare pre-edge outputs, advance model past the edge.
    task automatic tick(input logic e, input logic w, input logic [7:0] v);
        en = e; div_wr = w; div_val = v;
        #1;
        last_clk   = clk_out;
        last_pulse = clk_en_pulse;
        chk("clk_out", 32'(clk_out), 32'(exp_clk()));
        chk("clk_en_pulse", 32'(clk_en_pulse), (e && m_pos == m_n - 1) ? 32'd1 : 32'd0);
        chk("div_active", 32'(div_active), 32'(m_n));
        chk("div_pend", 32'(div_pend), 32'(m_pend));
        chk("div_err", 32'(div_err), 32'(m_err));
        @(posedge clk);
        #1;
        m_err = (w && v < 2) ? 1 : 0;
        if (!e || m_pos == m_n - 1) begin
            if (m_pend != 0) begin
                m_n = m_pval;
                m_pend = 0;
            end
            m_pos = 0;
        end else begin
            m_pos = m_pos + 1;
        end
        if (w && v >= 2) begin
            m_pend = 1;
            m_pval = int'(v);
        end
        div_wr = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'($urandom_range(0, 1)); div_wr = 1'b1; div_val = 8'd9;
        @(posedge clk);
        #1;
        rst = 1'b0; div_wr = 1'b0;
        model_reset();
    endtask

    task automatic align();
        for (int i = 0; i < 300 && m_pos != 0; i++) tick(1'b1, 1'b0, 8'd0);
        chk("align_timeout", 32'(m_pos), 32'd0);
    endtask

    task automatic measure(input int n, output int lo, output int hi);
        lo = 0; hi = 0;
        for (int i = 0; i < n; i++) begin
            tick(1'b1, 1'b0, 8'd0);
            if (last_clk) hi++; else lo++;
        end
    endtask

    initial begin
        int lo, hi, k;
        logic e, w;
        logic [7:0] v;

        model_reset();
        @(posedge clk);
        #1;
        do_reset();
        chk("rst_div_active", 32'(div_active), 32'd4);
        chk("rst_div_pend", 32'(div_pend), 32'd0);
        chk("rst_clk_out", 32'(clk_out), 32'd0);
        chk("rst_div_err", 32'(div_err), 32'd0);

        // Default N=4: 2 low / 2 high, one pulse per period.
        measure(4, lo, hi);
        chk("n4_low", 32'(lo), 32'd2);
        chk("n4_high", 32'(hi), 32'd2);
        measure(4, lo, hi);
        chk("n4_pulse_at_end", 32'(last_pulse), 32'd1);

        // Write 5 at cnt=1: pending until the cnt=3 wrap.
        tick(1'b1, 1'b0, 8'd0);
        tick(1'b1, 1'b1, 8'd5);
        chk("w5_pend", 32'(div_pend), 32'd1);
        tick(1'b1, 1'b0, 8'd0);
        chk("w5_active_old", 32'(div_active), 32'd4);
        tick(1'b1, 1'b0, 8'd0);
        chk("w5_active_new", 32'(div_active), 32'd5);
        chk("w5_pend_clr", 32'(div_pend), 32'd0);
        measure(5, lo, hi);
`ifdef CLK_DIV_ODD_DUTY50_EN
        chk("n5_low_sampled", 32'(lo), 32'd3);
        chk("n5_high_sampled", 32'(hi), 32'd2);
`else
        chk("n5_low", 32'(lo), 32'd2);
        chk("n5_high", 32'(hi), 32'd3);
`endif

        // Rejected writes.
        tick(1'b1, 1'b1, 8'd1);
        chk("err1", 32'(div_err), 32'd1);
        chk("err1_active", 32'(div_active), 32'd5);
        chk("err1_pend", 32'(div_pend), 32'd0);
        tick(1'b1, 1'b1, 8'd0);
        chk("err0", 32'(div_err), 32'd1);
        tick(1'b1, 1'b0, 8'd0);
        chk("err_clr", 32'(div_err), 32'd0);

        // Overwrite pending 6 with 8 before the boundary.
        align();
        tick(1'b1, 1'b1, 8'd6);
        tick(1'b1, 1'b1, 8'd8);
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 8'd0);
        chk("ovw_active", 32'(div_active), 32'd8);
        chk("ovw_pend", 32'(div_pend), 32'd0);

        // Drop en at cnt=2 with a pending 7.
        tick(1'b1, 1'b1, 8'd7);
        tick(1'b1, 1'b0, 8'd0);
        chk("en_pend", 32'(div_pend), 32'd1);
        tick(1'b0, 1'b0, 8'd0);
        chk("en_off_clk", 32'(clk_out), 32'd0);
        chk("en_off_active", 32'(div_active), 32'd7);
        chk("en_off_pend", 32'(div_pend), 32'd0);
        k = 0;
        for (int i = 1; i <= 20 && k == 0; i++) begin
            tick(1'b1, 1'b0, 8'd0);
            if (last_pulse) k = i;
        end
        chk("en_first_pulse", 32'(k), 32'd7);

        // N=255 then reset mid-period.
        tick(1'b1, 1'b1, 8'd255);
        align();
        chk("n255_active", 32'(div_active), 32'd255);
        measure(255, lo, hi);
`ifdef CLK_DIV_ODD_DUTY50_EN
        chk("n255_low_sampled", 32'(lo), 32'd128);
        chk("n255_high_sampled", 32'(hi), 32'd127);
`else
        chk("n255_low", 32'(lo), 32'd127);
        chk("n255_high", 32'(hi), 32'd128);
`endif
        for (int i = 0; i < 40; i++) tick(1'b1, 1'b0, 8'd0);
        tick(1'b1, 1'b1, 8'd9);
        do_reset();
        chk("midrst_active", 32'(div_active), 32'd4);
        chk("midrst_pend", 32'(div_pend), 32'd0);
        chk("midrst_clk", 32'(clk_out), 32'd0);
        measure(4, lo, hi);
        chk("midrst_low", 32'(lo), 32'd2);
        chk("midrst_high", 32'(hi), 32'd2);

        // Randomized traffic against the model.
        for (int i = 0; i < 800; i++) begin
            e = ($urandom_range(0, 99) < 85);
            w = ($urandom_range(0, 3) == 0);
            v = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 40)) : 8'($urandom_range(0, 9));
            if ($urandom_range(0, 199) == 0) do_reset();
            else tick(e, w, v);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
